// File: rtl/benes_cfg_sched.sv
// benes_cfg_sched: active/shadow routing configuration scheduler for the
// 8x8 Benes network. Drives per-stage switch_set slices and admits vectors.
// Optional feature macro: BENES_CFG_SKEW_EN. When it is defined, a commit in RUN
// updates the stages as a wavefront (SWAP). When it is undefined, a commit in RUN
// drains the network first (DRAIN) and then updates every stage at one edge.
module benes_cfg_sched #(
    parameter int N_STAGES     = 5,
    parameter int SW_PER_STAGE = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [N_STAGES*SW_PER_STAGE-1:0]   cfg_data,
    input  logic                               commit,
    output logic                               commit_ack,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [N_STAGES*SW_PER_STAGE-1:0]   switch_set,
    output logic                               out_valid,
    output logic                               cfg_loaded,
    output logic                               busy
);
    localparam int W = N_STAGES * SW_PER_STAGE;

    typedef enum logic [1:0] {EMPTY, RUN, SWAP, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [W-1:0]        shadow_q;
    logic [W-1:0]        pend_q;
    logic [W-1:0]        set_q;
    logic                shadow_full_q;
    logic                ack_q;
    logic [N_STAGES-1:0] vp_q;
    logic                wr;
    logic                accept;
    logic                admit;

`ifdef BENES_CFG_SKEW_EN
    localparam int CW = $clog2(N_STAGES + 1);
    logic [CW-1:0] cnt_q;
    logic          swap_last;
    assign swap_last = (cnt_q == CW'(N_STAGES - 1));
`else
    localparam logic [N_STAGES-1:0] TAIL_MASK = N_STAGES'(1) << (N_STAGES - 1);
    logic drain_done;
    // Only the tail may still be set: that vector has already passed every stage.
    assign drain_done = ((vp_q & ~TAIL_MASK) == '0);
`endif

    assign wr         = cfg_valid & ~shadow_full_q;
    assign accept     = commit & shadow_full_q & ((state_q == EMPTY) | (state_q == RUN));
    assign admit      = in_valid & in_ready;
    assign cfg_ready  = ~shadow_full_q;
    assign commit_ack = ack_q;
    assign switch_set = set_q;
    assign out_valid  = vp_q[N_STAGES-1];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // Next-state and status outputs
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        busy       = 1'b0;
        cfg_loaded = (state_q != EMPTY);
        case (state_q)
            EMPTY: if (accept) state_d = RUN;
`ifdef BENES_CFG_SKEW_EN
            RUN: begin
                in_ready = 1'b1;
                if (accept) state_d = SWAP;
            end
            SWAP: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (swap_last) state_d = RUN;
            end
`else
            RUN: begin
                in_ready = 1'b1;
                if (accept) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_done) state_d = RUN;
            end
`endif
            default: state_d = EMPTY;
        endcase
    end

    // Shadow register, commit acknowledge and admitted-vector pipe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            ack_q         <= 1'b0;
            vp_q          <= '0;
        end else begin
            ack_q <= accept;
            vp_q  <= (vp_q << 1) | N_STAGES'(admit);
            if (accept) begin
                shadow_full_q <= 1'b0;
            end else if (wr) begin
                shadow_full_q <= 1'b1;
                shadow_q      <= cfg_data;
            end
        end
    end

    // Active configuration: bulk load, wavefront update or post-drain update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q  <= '0;
            pend_q <= '0;
`ifdef BENES_CFG_SKEW_EN
            cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                EMPTY: if (accept) set_q <= shadow_q;
                RUN: if (accept) begin
                    pend_q <= shadow_q;
`ifdef BENES_CFG_SKEW_EN
                    // Stage 0 switches at the accepting edge; stage k follows k edges later.
                    set_q[SW_PER_STAGE-1:0] <= shadow_q[SW_PER_STAGE-1:0];
                    cnt_q                   <= CW'(1);
`endif
                end
`ifdef BENES_CFG_SKEW_EN
                SWAP: begin
                    set_q[int'(cnt_q)*SW_PER_STAGE +: SW_PER_STAGE] <=
                        pend_q[int'(cnt_q)*SW_PER_STAGE +: SW_PER_STAGE];
                    cnt_q <= cnt_q + CW'(1);
                end
`else
                DRAIN: if (drain_done) set_q <= pend_q;
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_benes_cfg_sched.sv
// Directed self-checking bench for benes_cfg_sched (5 stages x 4 switches).
`timescale 1ns/1ps
module tb_benes_cfg_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [19:0] cfg_data = '0;
    logic        commit = 1'b0;
    logic        commit_ack;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] switch_set;
    logic        out_valid;
    logic        cfg_loaded;
    logic        busy;

    int cmps = 0;
    int errs = 0;

    logic [25:0] st;
    assign st = {switch_set, out_valid, cfg_ready, in_ready, commit_ack, cfg_loaded, busy};
    localparam logic [25:0] RST_ST = {20'h00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    benes_cfg_sched #(.N_STAGES(5), .SW_PER_STAGE(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .commit(commit), .commit_ack(commit_ack),
        .in_valid(in_valid), .in_ready(in_ready),
        .switch_set(switch_set), .out_valid(out_valid),
        .cfg_loaded(cfg_loaded), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_cfg(input logic [19:0] d);
        cfg_valid = 1'b1;
        cfg_data  = d;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_commit;
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        cmps++; if (st !== RST_ST) begin errs++; $display("FAIL reset_state: got %h want %h", st, RST_ST); end
        rst_n = 1'b1;
        tick();
        cmps++; if (st !== RST_ST) begin errs++; $display("FAIL reset_release: got %h want %h", st, RST_ST); end
    endtask

    task automatic test_first_cfg;
        write_cfg(20'h00000);
        cmps++; if (cfg_ready !== 1'b0) begin errs++; $display("FAIL shadow_full: cfg_ready got %b want 0", cfg_ready); end
        pulse_commit();
        cmps++; if (st !== {20'h00000, 6'b011110}) begin errs++; $display("FAIL first_commit: got %h want %h", st, {20'h00000, 6'b011110}); end
        tick();
        cmps++; if (commit_ack !== 1'b0) begin errs++; $display("FAIL ack_pulse_width: got %b want 0", commit_ack); end
    endtask

    task automatic test_empty_commit;
        pulse_commit();
        cmps++; if ({commit_ack, busy, switch_set} !== 22'h0) begin errs++; $display("FAIL empty_commit: got %h want 0", {commit_ack, busy, switch_set}); end
    endtask

    task automatic test_latency;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cmps++;
            if (out_valid !== (i == 4)) begin errs++; $display("FAIL latency_%0d: out_valid got %b want %b", i, out_valid, (i == 4)); end
            tick();
        end
    endtask

    task automatic test_simul_write_commit;
        cfg_valid = 1'b1;
        cfg_data  = 20'hA5A5A;
        commit    = 1'b1;
        tick();
        cfg_valid = 1'b0;
        commit    = 1'b0;
        cmps++; if ({switch_set, commit_ack, cfg_ready} !== {20'h00000, 2'b00}) begin errs++; $display("FAIL simul_write_commit: got %h want %h", {switch_set, commit_ack, cfg_ready}, {20'h00000, 2'b00}); end
        pulse_commit();
        cmps++; if (commit_ack !== 1'b1) begin errs++; $display("FAIL later_commit_ack: got %b want 1", commit_ack); end
`ifdef BENES_CFG_SKEW_EN
        cmps++; if (switch_set !== 20'h0000A) begin errs++; $display("FAIL simul_slice0: got %h want 0000a", switch_set); end
        repeat (4) tick();
`else
        tick();
`endif
        cmps++; if ({switch_set, busy, in_ready} !== {20'hA5A5A, 2'b01}) begin errs++; $display("FAIL simul_final: got %h want %h", {switch_set, busy, in_ready}, {20'hA5A5A, 2'b01}); end
    endtask

`ifdef BENES_CFG_SKEW_EN
    task automatic test_skew_swap;
        logic [19:0] old_v, new_v, exp_v;
        old_v = 20'hA5A5A;
        new_v = 20'hFFFFF;
        write_cfg(new_v);
        in_valid = 1'b1;
        pulse_commit();
        for (int k = 0; k < 5; k++) begin
            for (int s = 0; s < 5; s++) exp_v[s*4 +: 4] = (s <= k) ? new_v[s*4 +: 4] : old_v[s*4 +: 4];
            cmps++; if (switch_set !== exp_v) begin errs++; $display("FAIL swap_slices_%0d: got %h want %h", k, switch_set, exp_v); end
            cmps++; if ({busy, in_ready, commit_ack} !== {(k < 4), 1'b1, (k == 0)}) begin errs++; $display("FAIL swap_status_%0d: got %b want %b", k, {busy, in_ready, commit_ack}, {(k < 4), 1'b1, (k == 0)}); end
            if (k == 0) begin
                cfg_valid = 1'b1;
                cfg_data  = 20'h0F0F0;
            end else if (k == 1) begin
                cfg_valid = 1'b0;
                commit    = 1'b1;
            end else begin
                commit = 1'b0;
            end
            if (k == 4) begin
                cmps++; if (cfg_ready !== 1'b0) begin errs++; $display("FAIL swap_write_kept: cfg_ready got %b want 0", cfg_ready); end
            end
            tick();
        end
        pulse_commit();
        cmps++; if (commit_ack !== 1'b1) begin errs++; $display("FAIL post_swap_commit: got %b want 1", commit_ack); end
        repeat (4) tick();
        cmps++; if (switch_set !== 20'h0F0F0) begin errs++; $display("FAIL post_swap_cfg: got %h want 0f0f0", switch_set); end
        in_valid = 1'b0;
    endtask
`else
    task automatic test_drain;
        write_cfg(20'h12345);
        in_valid = 1'b1;
        tick();
        tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        cmps++; if ({commit_ack, in_ready, busy, switch_set} !== {3'b101, 20'hA5A5A}) begin errs++; $display("FAIL drain_enter: got %h want %h", {commit_ack, in_ready, busy, switch_set}, {3'b101, 20'hA5A5A}); end
        for (int j = 1; j <= 9; j++) begin
            in_valid = (j <= 5);
            tick();
            cmps++; if (out_valid !== (j >= 2 && j <= 4)) begin errs++; $display("FAIL drain_out_valid_%0d: got %b want %b", j, out_valid, (j >= 2 && j <= 4)); end
            cmps++; if ({in_ready, busy} !== {(j >= 5), (j < 5)}) begin errs++; $display("FAIL drain_status_%0d: got %b want %b", j, {in_ready, busy}, {(j >= 5), (j < 5)}); end
            cmps++; if (switch_set !== ((j >= 5) ? 20'h12345 : 20'hA5A5A)) begin errs++; $display("FAIL drain_cfg_%0d: got %h want %h", j, switch_set, ((j >= 5) ? 20'h12345 : 20'hA5A5A)); end
        end
        in_valid = 1'b0;
    endtask
`endif

    task automatic test_reset_mid;
        write_cfg(20'h55555);
        in_valid = 1'b1;
        pulse_commit();
        tick();
        cmps++; if (busy !== 1'b1) begin errs++; $display("FAIL mid_busy: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        cmps++; if (st !== RST_ST) begin errs++; $display("FAIL reset_async: got %h want %h", st, RST_ST); end
        tick();
        cmps++; if (st !== RST_ST) begin errs++; $display("FAIL reset_held: got %h want %h", st, RST_ST); end
        rst_n = 1'b1;
        repeat (6) tick();
        cmps++; if ({in_ready, out_valid, cfg_loaded, busy, switch_set} !== 24'h0) begin errs++; $display("FAIL post_reset_idle: got %h want 0", {in_ready, out_valid, cfg_loaded, busy, switch_set}); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_cfg();
        test_empty_commit();
        test_latency();
        test_simul_write_commit();
`ifdef BENES_CFG_SKEW_EN
        test_skew_swap();
`else
        test_drain();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
